// File: rtl/demuxn_deserialiser.sv
// Serial-to-parallel receiver: slots one bit per valid beat by its select index,
// checks the 0..N-1 index order and publishes each complete word with a valid pulse.
module demuxn_deserialiser #(
    parameter int unsigned N    = 8,
    parameter int unsigned SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            din,
    input  logic [SELW-1:0] sel,
    input  logic            din_valid,
    output logic [N-1:0]    dout,
    output logic            dout_valid,
    output logic            seq_err,
    output logic [7:0]      frame_cnt
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    state_t          r_state;
    logic [SELW-1:0] r_exp;
    logic [N-1:0]    r_sh;
    logic [N-1:0]    r_dout;
    logic            r_dout_valid;
    logic            r_seq_err;
    logic [7:0]      r_frame_cnt;

    state_t          w_state_nx;
    logic [SELW-1:0] w_exp_nx;
    logic [N-1:0]    w_sh_nx;
    logic [N-1:0]    w_dout_nx;
    logic            w_dout_valid_nx;
    logic            w_seq_err_nx;
    logic [7:0]      w_frame_cnt_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_exp        <= '0;
            r_sh         <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_seq_err    <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_exp        <= w_exp_nx;
            r_sh         <= w_sh_nx;
            r_dout       <= w_dout_nx;
            r_dout_valid <= w_dout_valid_nx;
            r_seq_err    <= w_seq_err_nx;
            r_frame_cnt  <= w_frame_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_exp_nx        = r_exp;
        w_sh_nx         = r_sh;
        w_dout_nx       = r_dout;
        w_dout_valid_nx = 1'b0;
        w_seq_err_nx    = 1'b0;
        w_frame_cnt_nx  = r_frame_cnt;

        if (din_valid) begin
            unique case (r_state)
                IDLE: begin
                    if (sel == '0) begin
                        w_sh_nx[0] = din;
                        w_exp_nx   = SELW'(1);
                        w_state_nx = COLLECT;
                    end else begin
                        w_seq_err_nx = 1'b1;
                    end
                end
                COLLECT: begin
                    if (sel == r_exp) begin
                        if (r_exp == LAST) begin
                            // Last bit bypasses the shadow register so back-to-back frames need no bubble.
                            w_dout_nx       = {din, r_sh[N-2:0]};
                            w_dout_valid_nx = 1'b1;
                            w_frame_cnt_nx  = r_frame_cnt + 8'd1;
                            w_exp_nx        = '0;
                            w_state_nx      = IDLE;
                        end else begin
                            w_sh_nx[r_exp] = din;
                            w_exp_nx       = r_exp + SELW'(1);
                        end
                    end else begin
                        w_seq_err_nx = 1'b1;
                        if (sel == '0) begin
                            w_sh_nx[0] = din;
                            w_exp_nx   = SELW'(1);
                        end else begin
                            w_exp_nx   = '0;
                            w_state_nx = IDLE;
                        end
                    end
                end
                default: begin
                    w_exp_nx   = '0;
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign seq_err    = r_seq_err;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_demuxn_deserialiser.sv
// Scoreboard bench for demuxn_deserialiser: directed frames push expected
// output events; a negedge monitor pops and checks every pulse and reset state.
module tb_demuxn_deserialiser;

    localparam int unsigned N    = 8;
    localparam int unsigned SELW = 3;

    logic            clk;
    logic            reset_n;
    logic            din;
    logic [SELW-1:0] sel;
    logic            din_valid;
    logic [N-1:0]    dout;
    logic            dout_valid;
    logic            seq_err;
    logic [7:0]      frame_cnt;

    demuxn_deserialiser #(.N(N), .SELW(SELW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .sel        (sel),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .seq_err    (seq_err),
        .frame_cnt  (frame_cnt)
    );

    typedef struct {
        bit       is_err;
        bit [7:0] dout;
        bit [7:0] cnt;
        int       gap;   // required cycles since previous dout_valid, 0 = unchecked
    } ev_t;

    ev_t q[$];
    int  vectors;
    int  miscompares;
    int  cyc;
    int  last_dv;
    bit  done;

    bit [7:0] m_dout;
    bit [7:0] m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sole owner of the comparison counters.
    always @(negedge clk) begin
        ev_t e;
        if (done) begin
            vectors = vectors + 1;
            if (q.size() != 0) begin
                miscompares = miscompares + 1;
                $display("FAIL missing_pulses: %0d expected events never seen, required 0", q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end else if (reset_n === 1'b0) begin
            vectors = vectors + 1;
            if (dout !== 8'h00 || dout_valid !== 1'b0 || seq_err !== 1'b0 || frame_cnt !== 8'h00) begin
                miscompares = miscompares + 1;
                $display("FAIL reset_state: dout=%h dv=%b err=%b cnt=%0d, required all 0",
                         dout, dout_valid, seq_err, frame_cnt);
            end
        end else if (dout_valid === 1'b1 && seq_err === 1'b1) begin
            vectors = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL exclusive: dout_valid=1 seq_err=1, required at most one");
        end else if (dout_valid === 1'b1 || seq_err === 1'b1) begin
            vectors = vectors + 1;
            if (q.size() == 0) begin
                miscompares = miscompares + 1;
                $display("FAIL unexpected_pulse: dout_valid=%b seq_err=%b dout=%h, required no pulse",
                         dout_valid, seq_err, dout);
            end else begin
                e = q.pop_front();
                if (seq_err !== e.is_err || dout !== e.dout || frame_cnt !== e.cnt) begin
                    miscompares = miscompares + 1;
                    $display("FAIL event: err=%b dout=%h cnt=%0d, required err=%b dout=%h cnt=%0d",
                             seq_err, dout, frame_cnt, e.is_err, e.dout, e.cnt);
                end
                if (dout_valid === 1'b1) begin
                    if (e.gap != 0 && (cyc - last_dv) != e.gap) begin
                        miscompares = miscompares + 1;
                        $display("FAIL dv_spacing: %0d cycles, required %0d", cyc - last_dv, e.gap);
                    end
                    last_dv = cyc;
                end
            end
        end
    end

    task automatic beat(input int unsigned s, input logic d);
        @(negedge clk);
        din_valid = 1'b1;
        sel       = SELW'(s);
        din       = d;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0;
        end
    endtask

    task automatic push_err();
        ev_t e;
        e.is_err = 1'b1;
        e.dout   = m_dout;
        e.cnt    = m_cnt;
        e.gap    = 0;
        q.push_back(e);
    endtask

    // gapmask[k] inserts 3 idle cycles after beat k; restart flags beat 0 as an abort.
    task automatic send_frame(input logic [7:0] x, input bit restart,
                              input logic [7:0] gapmask, input int gap);
        ev_t e;
        for (int unsigned k = 0; k < N; k++) begin
            if (k == 0 && restart) push_err();
            if (k == N - 1) begin
                m_dout   = x;
                m_cnt    = m_cnt + 8'd1;
                e.is_err = 1'b0;
                e.dout   = m_dout;
                e.cnt    = m_cnt;
                e.gap    = gap;
                q.push_back(e);
            end
            beat(k, x[k]);
            if (gapmask[k]) idle(3);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        last_dv     = 0;
        done        = 1'b0;
        m_dout      = 8'h00;
        m_cnt       = 8'h00;
        din         = 1'b0;
        sel         = '0;
        din_valid   = 1'b0;
        reset_n     = 1'b1;
        #2 reset_n  = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n  = 1'b1;

        // Clean frame, then the same frame with idle gaps inside
        send_frame(8'hAC, 1'b0, 8'h00, 0);
        idle(2);
        send_frame(8'hAC, 1'b0, 8'b0001_0010, 0);
        idle(2);

        // Back-to-back frames: second pulse exactly 8 cycles after the first
        send_frame(8'hAC, 1'b0, 8'h00, 0);
        send_frame(8'h53, 1'b0, 8'h00, 8);
        idle(2);

        // Skipped index aborts to IDLE; dout holds 8'h53
        beat(0, 1'b1);
        beat(1, 1'b0);
        beat(2, 1'b1);
        push_err();
        beat(5, 1'b1);
        idle(2);
        send_frame(8'hFF, 1'b0, 8'h00, 0);
        idle(2);

        // Non-zero index in IDLE is discarded
        push_err();
        beat(3, 1'b1);
        idle(2);

        // Restart mid-frame with sel==0
        beat(0, 1'b0);
        beat(1, 1'b1);
        beat(2, 1'b0);
        beat(3, 1'b1);
        send_frame(8'h0F, 1'b1, 8'h00, 0);
        idle(2);

        // Asynchronous reset mid-frame
        beat(0, 1'b1);
        beat(1, 1'b0);
        beat(2, 1'b1);
        beat(3, 1'b0);
        beat(4, 1'b1);
        @(posedge clk);
        #2;
        reset_n   = 1'b0;
        din_valid = 1'b0;
        m_dout    = 8'h00;
        m_cnt     = 8'h00;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        send_frame(8'hA5, 1'b0, 8'h00, 0);
        idle(2);

        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #2 done = 1'b1;
    end

endmodule
